sprite_bank: RTL and testbench

SPRITE_BANK -- requirements
Module: sprite_bank

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_ram.sv | 24 ++
 rtl/sprite_bank.sv | 172 +++++++++++++++++
 tb/tb_sprite_bank.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared defaults, per-sprite sizing helper and write-FSM state encoding
// for the sprite bank.
package sprite_pkg;

  localparam int DEF_NUM_SPRITES = 8;
  localparam int DEF_SPRITE_W    = 32;
  localparam int DEF_SPRITE_H    = 32;
  localparam int DEF_BPP         = 4;

  function automatic int bytes_per_sprite(input int w, input int h, input int bpp);
    return (w * h * bpp) / 8;
  endfunction

  localparam int DEF_BYTES_PER_SPRITE =
    bytes_per_sprite(DEF_SPRITE_W, DEF_SPRITE_H, DEF_BPP);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_FULL    = 2'd2,
    ST_DISCARD = 2'd3
  } wr_state_e;

endpackage

// File: rtl/sprite_ram.sv
// Simple dual-port byte RAM: one write port, one read port with registered output.
// A read of the byte being written in the same cycle returns the old contents.
module sprite_ram
  import sprite_pkg::*;
#(
  parameter int DEPTH  = DEF_NUM_SPRITES * DEF_BYTES_PER_SPRITE,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/sprite_bank.sv
// Multi-slot sprite store: byte-stream upload per slot through a small write FSM,
// and a two-stage pipelined pixel read that returns 0 for incomplete slots.
module sprite_bank
  import sprite_pkg::*;
#(
  parameter int NUM_SPRITES = DEF_NUM_SPRITES,
  parameter int SPRITE_W    = DEF_SPRITE_W,
  parameter int SPRITE_H    = DEF_SPRITE_H,
  parameter int BPP         = DEF_BPP
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           wr_en,
  input  logic                           wr_valid,
  input  logic [7:0]                     wr_data,
  input  logic [7:0]                     wr_id,
  output logic                           wr_done,
  output logic                           wr_err,
  output logic [NUM_SPRITES-1:0]         slot_valid,
  input  logic                           rd_req,
  input  logic [$clog2(NUM_SPRITES)-1:0] rd_id,
  input  logic [$clog2(SPRITE_W)-1:0]    rd_x,
  input  logic [$clog2(SPRITE_H)-1:0]    rd_y,
  output logic                           rd_valid,
  output logic [BPP-1:0]                 rd_pixel
);

  localparam int BPS     = bytes_per_sprite(SPRITE_W, SPRITE_H, BPP);
  localparam int ID_W    = $clog2(NUM_SPRITES);
  localparam int ID_SPAN = 1 << ID_W;
  localparam int PTR_W   = $clog2(BPS);
  localparam int DEPTH   = NUM_SPRITES * BPS;
  localparam int ADDR_W  = $clog2(DEPTH);
  localparam int PIX_W   = $clog2(SPRITE_W * SPRITE_H);
  localparam int PPB     = 8 / BPP;
  localparam int SEL_W   = (PPB > 1) ? $clog2(PPB) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BPS - 1);

  wr_state_e         state, state_next;
  logic [PTR_W-1:0]  ptr, ptr_next, wptr;
  logic [ID_W-1:0]   slot, slot_next, wslot;
  logic              wr_en_prev;
  logic              we, set_valid, clr_valid, done_next, err_next;
  logic              id_ok;
  logic [ADDR_W-1:0] waddr, raddr;
  logic [7:0]        ram_rdata;

  assign id_ok = 32'(wr_id) < NUM_SPRITES;

  // A frame only starts on a low-to-high wr_en; wr_en_prev resets high so a
  // level held across reset release cannot open a frame.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    slot_next  = slot;
    wslot      = slot;
    wptr       = ptr;
    we         = 1'b0;
    set_valid  = 1'b0;
    clr_valid  = 1'b0;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (wr_en && !wr_en_prev) begin
          if (id_ok) begin
            state_next = ST_LOAD;
            slot_next  = ID_W'(wr_id);
            wslot      = ID_W'(wr_id);
            wptr       = '0;
            ptr_next   = '0;
            clr_valid  = 1'b1;
            if (wr_valid) begin
              we       = 1'b1;
              ptr_next = PTR_W'(1);
            end
          end else begin
            state_next = ST_DISCARD;
            err_next   = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (!wr_en) begin
          state_next = ST_IDLE;
          ptr_next   = '0;
        end else if (wr_valid) begin
          we = 1'b1;
          if (ptr == LAST_PTR) begin
            set_valid  = 1'b1;
            done_next  = 1'b1;
            state_next = ST_FULL;
          end else begin
            ptr_next = ptr + 1'b1;
          end
        end
      end
      ST_FULL: begin
        if (!wr_en) state_next = ST_IDLE;
        else if (wr_valid) err_next = 1'b1;
      end
      ST_DISCARD: begin
        if (!wr_en) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      slot       <= '0;
      wr_en_prev <= 1'b1;
      slot_valid <= '0;
      wr_done    <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      slot       <= slot_next;
      wr_en_prev <= wr_en;
      wr_done    <= done_next;
      wr_err     <= err_next;
      if (clr_valid) slot_valid[wslot] <= 1'b0;
      if (set_valid) slot_valid[slot]  <= 1'b1;
    end
  end

  assign waddr = ADDR_W'(wslot) * ADDR_W'(BPS) + ADDR_W'(wptr);

  // Read address: row-major pixel index, packed PPB pixels per byte.
  logic [PIX_W-1:0]   rd_pix;
  logic [ID_SPAN-1:0] valid_ext;
  logic               req_q, ok_q;
  logic [SEL_W-1:0]   sel_q;
  logic [BPP-1:0]     rd_field;

  assign rd_pix    = PIX_W'(rd_y) * PIX_W'(SPRITE_W) + PIX_W'(rd_x);
  assign raddr     = ADDR_W'(rd_id) * ADDR_W'(BPS) + ADDR_W'(rd_pix / PIX_W'(PPB));
  assign valid_ext = ID_SPAN'(slot_valid);
  assign rd_field  = ram_rdata[32'(sel_q) * BPP +: BPP];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q    <= 1'b0;
      ok_q     <= 1'b0;
      sel_q    <= '0;
      rd_valid <= 1'b0;
      rd_pixel <= '0;
    end else begin
      req_q    <= rd_req;
      ok_q     <= rd_req & valid_ext[rd_id];
      sel_q    <= SEL_W'(rd_pix % PIX_W'(PPB));
      rd_valid <= req_q;
      rd_pixel <= ok_q ? rd_field : '0;
    end
  end

  sprite_ram #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (wr_data),
    .raddr (raddr),
    .rdata (ram_rdata)
  );

endmodule

// File: tb/tb_sprite_bank.sv
// Randomized self-checking bench for sprite_bank against a byte-array model
// of slot contents and slot validity.
module tb_sprite_bank;

  localparam int NUM = 8;
  localparam int W   = 32;
  localparam int H   = 32;
  localparam int BPP = 4;
  localparam int BPS = W * H * BPP / 8;
  localparam int PPB = 8 / BPP;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           wr_en, wr_valid;
  logic [7:0]     wr_data, wr_id;
  logic           wr_done, wr_err;
  logic [NUM-1:0] slot_valid;
  logic           rd_req;
  logic [2:0]     rd_id;
  logic [4:0]     rd_x, rd_y;
  logic           rd_valid;
  logic [3:0]     rd_pixel;

  always #5 clk = ~clk;

  sprite_bank dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wr_en      (wr_en),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_id      (wr_id),
    .wr_done    (wr_done),
    .wr_err     (wr_err),
    .slot_valid (slot_valid),
    .rd_req     (rd_req),
    .rd_id      (rd_id),
    .rd_x       (rd_x),
    .rd_y       (rd_y),
    .rd_valid   (rd_valid),
    .rd_pixel   (rd_pixel)
  );

  int checks = 0;
  int errors = 0;
  int done_seen, err_seen, rvalid_seen;

  logic [7:0]     model_mem [NUM][BPS];
  logic [NUM-1:0] model_valid;

  typedef struct {
    bit         v;
    logic [3:0] p;
  } rd_exp_t;
  rd_exp_t exp_q[$];

  function automatic logic [3:0] model_pixel(input int id, input int x, input int y);
    int pix;
    logic [7:0] b;
    if (id >= NUM || !model_valid[id]) return 4'h0;
    pix = y * W + x;
    b = model_mem[id][pix / PPB];
    return 4'((b >> ((pix % PPB) * BPP)) & 8'h0F);
  endfunction

  // One clock: record the expected read result of the current request,
  // advance, then check the read issued two cycles earlier.
  task automatic tick();
    rd_exp_t e, h;
    e.v = rd_req;
    e.p = rd_req ? model_pixel(int'(rd_id), int'(rd_x), int'(rd_y)) : 4'h0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    done_seen   += int'(wr_done);
    err_seen    += int'(wr_err);
    rvalid_seen += int'(rd_valid);
    if (exp_q.size() == 2) begin
      h = exp_q.pop_front();
      checks++;
      if (rd_valid !== h.v) begin
        errors++;
        $display("FAIL rd_valid at %0t: got %b expected %b", $time, rd_valid, h.v);
      end else if (h.v) begin
        checks++;
        if (rd_pixel !== h.p) begin
          errors++;
          $display("FAIL rd_pixel at %0t: got %h expected %h", $time, rd_pixel, h.p);
        end
      end
    end
  endtask

  task automatic rand_read();
    rd_req = ($urandom_range(0, 1) == 1);
    rd_id  = 3'($urandom_range(0, NUM - 1));
    rd_x   = 5'($urandom_range(0, W - 1));
    rd_y   = 5'($urandom_range(0, H - 1));
  endtask

  // Streams n accepted bytes into a slot with random gaps; leaves wr_en high.
  task automatic do_upload(input int slot, input int n, input bit inc);
    int i = 0;
    bit first = 1'b1;
    wr_en = 1'b1;
    wr_id = 8'(slot);
    while (i < n) begin
      rand_read();
      wr_valid = first ? 1'b1 : ($urandom_range(0, 3) != 0);
      wr_data  = inc ? 8'(16 + i) : 8'($urandom);
      tick();
      if (first) model_valid[slot] = 1'b0;
      first = 1'b0;
      if (wr_valid) begin
        model_mem[slot][i] = wr_data;
        i++;
        if (i == BPS) model_valid[slot] = 1'b1;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic end_frame();
    wr_en = 1'b0;
    wr_valid = 1'b0;
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({wr_done, wr_err, rd_valid, rd_pixel, slot_valid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected all zero",
               {wr_done, wr_err, rd_valid, rd_pixel, slot_valid});
    end
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_upload_slot3();
    done_seen = 0;
    do_upload(3, BPS, 1'b1);
    checks++;
    if (wr_done !== 1'b1 || done_seen != 1) begin
      errors++;
      $display("FAIL upload_done: wr_done=%b pulses=%0d expected 1 and 1", wr_done, done_seen);
    end
    checks++;
    if (slot_valid !== 8'h08) begin
      errors++;
      $display("FAIL upload_slot_valid: got %h expected 08", slot_valid);
    end
    rd_req = 1'b0;
    tick();
    checks++;
    if (wr_done !== 1'b0) begin
      errors++;
      $display("FAIL done_one_cycle: got %b expected 0", wr_done);
    end
  endtask

  task automatic test_read_pixel();
    rd_req = 1'b1; rd_id = 3'd3; rd_x = 5'd1; rd_y = 5'd0;
    tick();
    rd_req = 1'b0;
    checks++;
    if (rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_latency_early: rd_valid=%b expected 0", rd_valid);
    end
    tick();
    checks++;
    if (rd_valid !== 1'b1 || rd_pixel !== 4'h1) begin
      errors++;
      $display("FAIL read_x1y0: valid=%b pixel=%h expected 1 and 1", rd_valid, rd_pixel);
    end
  endtask

  task automatic test_overflow();
    err_seen = 0;
    wr_valid = 1'b1;
    wr_data = 8'hAA;
    tick();
    checks++;
    if (wr_err !== 1'b1) begin
      errors++;
      $display("FAIL overflow_err: got %b expected 1", wr_err);
    end
    wr_valid = 1'b0;
    tick();
    checks++;
    if (wr_err !== 1'b0 || err_seen != 1) begin
      errors++;
      $display("FAIL overflow_pulse: wr_err=%b pulses=%0d expected 0 and 1", wr_err, err_seen);
    end
    end_frame();
    for (int x = 0; x < W; x++) begin
      rd_req = 1'b1; rd_id = 3'd3; rd_x = 5'(x); rd_y = 5'($urandom_range(0, H - 1));
      tick();
    end
    rd_req = 1'b1; rd_id = 3'd3; rd_x = 5'd30; rd_y = 5'd31;
    tick();
    rd_req = 1'b0;
    tick();
  endtask

  task automatic test_partial();
    do_upload(5, 100, 1'b0);
    end_frame();
    checks++;
    if (slot_valid !== 8'h08) begin
      errors++;
      $display("FAIL partial_slot_valid: got %h expected 08", slot_valid);
    end
    for (int k = 0; k < 20; k++) begin
      rand_read();
      rd_req = 1'b1;
      rd_id = 3'd5;
      tick();
    end
    end_frame();
  endtask

  task automatic test_bad_id_burst();
    err_seen = 0;
    rd_req = 1'b0;
    wr_en = 1'b1;
    wr_id = 8'd9;
    wr_valid = 1'b1;
    wr_data = 8'($urandom);
    tick();
    checks++;
    if (wr_err !== 1'b1) begin
      errors++;
      $display("FAIL bad_id_err: got %b expected 1", wr_err);
    end
    repeat (5) begin
      wr_data = 8'($urandom);
      tick();
    end
    end_frame();
    checks++;
    if (err_seen != 1 || slot_valid !== 8'h08) begin
      errors++;
      $display("FAIL bad_id_effect: pulses=%0d slot_valid=%h expected 1 and 08", err_seen, slot_valid);
    end
    tick();
    rvalid_seen = 0;
    for (int x = 0; x < W; x++) begin
      rd_req = 1'b1; rd_id = 3'd3; rd_x = 5'(x); rd_y = 5'($urandom_range(0, H - 1));
      tick();
    end
    rd_req = 1'b0;
    tick();
    tick();
    checks++;
    if (rvalid_seen != 32) begin
      errors++;
      $display("FAIL burst_rd_valid_count: got %0d expected 32", rvalid_seen);
    end
  endtask

  task automatic test_random_upload();
    done_seen = 0;
    do_upload(6, BPS, 1'b0);
    end_frame();
    checks++;
    if (done_seen != 1 || slot_valid !== 8'h48) begin
      errors++;
      $display("FAIL slot6_upload: pulses=%0d slot_valid=%h expected 1 and 48", done_seen, slot_valid);
    end
    repeat (300) begin
      rand_read();
      tick();
    end
    end_frame();
  endtask

  task automatic test_reset_mid();
    do_upload(2, 50, 1'b0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_done, wr_err, rd_valid, rd_pixel, slot_valid} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b expected all zero",
               {wr_done, wr_err, rd_valid, rd_pixel, slot_valid});
    end
    model_valid = '0;
    exp_q.delete();
    wr_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_seen = 0;
    err_seen = 0;
    repeat (8) begin
      rand_read();
      wr_data = 8'($urandom);
      tick();
    end
    checks++;
    if (slot_valid !== 8'h00 || done_seen != 0 || err_seen != 0) begin
      errors++;
      $display("FAIL reset_release: slot_valid=%h done=%0d err=%0d expected 00 0 0",
               slot_valid, done_seen, err_seen);
    end
    end_frame();
    done_seen = 0;
    do_upload(2, BPS, 1'b0);
    end_frame();
    checks++;
    if (done_seen != 1 || slot_valid !== 8'h04) begin
      errors++;
      $display("FAIL reupload_slot2: pulses=%0d slot_valid=%h expected 1 and 04", done_seen, slot_valid);
    end
    repeat (100) begin
      rand_read();
      tick();
    end
    end_frame();
    tick();
  endtask

  initial begin
    wr_en = 1'b0; wr_valid = 1'b0; wr_data = '0; wr_id = '0;
    rd_req = 1'b0; rd_id = '0; rd_x = '0; rd_y = '0;
    model_valid = '0;
    done_seen = 0; err_seen = 0; rvalid_seen = 0;
    test_reset();
    test_upload_slot3();
    test_read_pixel();
    test_overflow();
    test_partial();
    test_bad_id_burst();
    test_random_upload();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
